four_bit_full_adder: RTL and testbench

//   Registered 4-bit unsigned adder: s,c = a + b, captured on the clock edge.

---
 rtl/four_bit_adder_pkg.sv | 29 ++
 rtl/full_adder_cell.sv | 27 ++
 rtl/four_bit_full_adder.sv | 91 +++++++++
 tb/tb_four_bit_full_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/four_bit_adder_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_adder_pkg
//   Shared definitions for the registered 4-bit ripple-carry adder.
//   - WIDTH     : operand width. It is fixed at 4 because it sets the length of
//                 the ripple chain.
//   - nibble_t  : one operand or one sum word.
//   - add_res_t : sum bits plus carry-out, which the top registers together.
//   - ovf_f     : two's-complement overflow of a nibble addition. The top uses
//                 it only when FBFA_OVF_EN is defined.
// -----------------------------------------------------------------------------
package four_bit_adder_pkg;

  localparam int WIDTH = 4;

  typedef logic [WIDTH-1:0] nibble_t;

  typedef struct packed {
    nibble_t s;
    logic    c;
  } add_res_t;

  // The signed result overflows when both operands have the same sign and the
  // sum has the other sign.
  function automatic logic ovf_f(input nibble_t op_a, input nibble_t op_b,
                                 input nibble_t sum);
    return (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
//   1-bit full adder, purely combinational. One cell forms one link of the
//   ripple-carry chain in four_bit_full_adder.
//   Ports:
//     a, b : operand bits
//     ci   : carry in from the previous cell
//     s    : sum bit
//     co   : carry out to the next cell
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_s;

  // The half-sum is computed once and feeds both the sum and the
  // propagate term of the carry.
  assign half_s = a ^ b;
  assign s      = half_s ^ ci;
  assign co     = (a & b) | (ci & half_s);

endmodule

// File: rtl/four_bit_full_adder.sv
// -----------------------------------------------------------------------------
// four_bit_full_adder
//   Registered 4-bit unsigned adder: {c,s} = a + b, with 1-cycle latency.
//   Four full_adder_cell instances form a ripple chain. The carry into cell 0
//   is tied to 0.
//   Ports:
//     clk  : clock, rising-edge active
//     rst  : synchronous reset, active-high. It clears all outputs and takes
//            priority over the data path.
//     a, b : 4-bit unsigned operands
//     s    : registered sum bits [3:0]
//     c    : registered carry-out (sum bit 4)
//     ovf  : registered two's-complement overflow. This port exists only when
//            the macro FBFA_OVF_EN is defined.
//   Configuration macro: FBFA_OVF_EN (adds the ovf port and its register).
// -----------------------------------------------------------------------------
module four_bit_full_adder
  import four_bit_adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c
`ifdef FBFA_OVF_EN
  ,
  output logic             ovf
`endif
);

  // carry_s[i] enters cell i; carry_s[WIDTH] is the carry-out of the adder.
  logic [WIDTH:0]   carry_s;
  nibble_t          sum_s;
  add_res_t         res_d;
  add_res_t         res_q;

  assign carry_s[0] = 1'b0;

  // Ripple chain: each cell consumes the carry produced by the cell below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (sum_s[i]),
      .co (carry_s[i+1])
    );
  end

  // Collect the combinational result into the next-state word.
  always_comb begin
    res_d.s = sum_s;
    res_d.c = carry_s[WIDTH];
  end

  // Output register. The synchronous reset overrides the new sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q.s <= 4'b0000;
      res_q.c <= 1'b0;
    end else begin
      res_q <= res_d;
    end
  end

  assign s = res_q.s;
  assign c = res_q.c;

`ifdef FBFA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow, computed from the same operands and sum as the result.
  always_comb begin
    ovf_d = ovf_f(a, b, sum_s);
  end

  // Overflow register. It is cleared together with the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_full_adder.sv
// -----------------------------------------------------------------------------
// tb_four_bit_full_adder
//   Scoreboard bench for four_bit_full_adder.
//   - The stimulus process drives inputs on the falling edge and pushes the
//     expected result of that edge.
//   - The monitor pops one entry per rising edge and compares it, because the
//     adder produces a new result every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_four_bit_full_adder;

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic       c;
`ifdef FBFA_OVF_EN
  logic       ovf;
`endif

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  bit   stim_done = 1'b0;

  four_bit_full_adder dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .s   (s),
    .c   (c)
`ifdef FBFA_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs for the next rising edge and record the expected
  // result.
  task automatic drive(input logic r, input logic [3:0] ta, input logic [3:0] tb_,
                       input logic [3:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = ta;
    b   = tb_;
    e.s   = es;
    e.c   = ec;
    e.ovf = eo;
    exp_q.push_back(e);
  endtask

  // Monitor: compares one result per rising edge, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (s === e.s && c === e.c
`ifdef FBFA_OVF_EN
            && ovf === e.ovf
`endif
           ) begin
          pass_cnt++;
        end else begin
          $display("FAIL result: a=%b b=%b rst=%b got s=%b c=%b, expected s=%b c=%b ovf=%b",
                   a, b, rst, s, c, e.s, e.c, e.ovf);
        end
      end
    end
  end

  // Stimulus: directed vectors first, then the full operand sweep.
  initial begin
    logic [4:0] sum5;
    logic [3:0] va;
    logic [3:0] vb;
    logic       eo;
    int         wait_cyc;
    rst = 1'b1;
    a   = 4'b0000;
    b   = 4'b0000;

    // Reset held for two edges with zero operands.
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Directed vectors, applied back-to-back on consecutive cycles.
    drive(1'b0, 4'b1001, 4'b1100, 4'b0101, 1'b1, 1'b1);
    drive(1'b0, 4'b0011, 4'b1010, 4'b1101, 1'b0, 1'b0);
    drive(1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0);
    drive(1'b0, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b1);
    drive(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0110, 4'b0001, 4'b0111, 1'b0, 1'b0);

    // Reset while the operands are 1111+1111, then release it.
    drive(1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0);

    // Exhaustive sweep of all 256 operand pairs, one pair per cycle.
    for (int i = 0; i < 256; i++) begin
      va   = i[7:4];
      vb   = i[3:0];
      sum5 = {1'b0, va} + {1'b0, vb};
      eo   = (va[3] == vb[3]) && (sum5[3] != va[3]);
      drive(1'b0, va, vb, sum5[3:0], sum5[4], eo);
    end

    // Wait a bounded number of cycles for the scoreboard to drain.
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Watchdog: stops the run if the stimulus process never completes.
  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus not complete, expected completion before 100000 ns");
      $fatal(1, "timeout");
    end
  end

endmodule
